ring_counter_core: RTL and testbench
====================================

# ring_counter_core

One-hot ring counter: a single `1` circulates through a WIDTH-bit register, advancing one position per enabled clock. Used as a phase/slot sequencer that drives per-slot enables and strobes in a round-robin schedule. Supports direction control, synchronous load and a one-hot integrity flag.

## Interface
- `WIDTH`, default 4, ring length in bits (≥2)
- `RESET_VAL`, default `{{(WIDTH-1){1'b0}},1'b1}` (4'b0001), value loaded on reset; must be one-hot
- `clk`  in  1  single clock, rising-edge active
- `rst`  in  1  reset, synchronous, active-low (sampled on rising `clk`; `rst`=0 resets)
- `en`  in  1  advance enable; 0 holds `out`
- `dir`  in  1  0 = rotate left (bit i → i+1, MSB → bit 0), 1 = rotate right
- `load`  in  1  synchronous load of `load_val`
- `load_val`  in  WIDTH  value to load
- `out`  out  WIDTH  ring state, registered
- `wrap`  out  1  registered; 1 for the cycle in which `out` equals `RESET_VAL` after a rotation (not after reset/load)
- `err`  out  1  combinational; 1 when `out` is not exactly one-hot

## Operation
- Priority per rising edge: `rst`=0 > `load` > `en` > hold.
- Reset: `out`←RESET_VAL, `wrap`←0.
- Load: `out`←`load_val` unchanged (any pattern accepted), `wrap`←0.
- Enabled rotate left: `out`←{out[WIDTH-2:0], out[WIDTH-1]}; right: {out[0], out[WIDTH-1:1]}.
- `wrap`←1 iff a rotation occurred and the next `out` equals RESET_VAL; else 0.
- Hold (`en`=0, `load`=0): `out` unchanged, `wrap`←0.
- `err` = ($countones(out) != 1); all-zero and multi-hot both flag.
- `dir` may change any cycle; takes effect at the next enabled edge.

## Timing
- All state updates on rising `clk`; latency 1 cycle from `en`/`load`/`rst` to `out`.
- Period WIDTH enabled cycles; WIDTH=4 left: 0001→0010→0100→1000→0001.
- `rst` deasserted mid-sequence resumes from RESET_VAL on the next edge with `en`=1.
- `load` and `en` asserted together: load wins, no rotation that cycle.
- `err` valid same cycle as `out`; no pipeline.

## Configuration
- `RING_COUNTER_SELFCORRECT_EN` defined: on an enabled edge where `err`=1 (and no `load`), `out`←RESET_VAL instead of rotating; `wrap`←0. Recovers from corrupted/loaded illegal states within one enabled cycle.
- Not defined: illegal patterns rotate as-is (all-zero stays zero, multi-hot keeps circulating); `err` stays asserted.

## Structure
- Package `ring_counter_pkg`: default WIDTH constant, `dir_e` enum (DIR_LEFT=0, DIR_RIGHT=1), function computing default RESET_VAL for a given WIDTH.
- One sub-module: `onehot_check` (WIDTH-parameterised, combinational, outputs `err`), reused by other one-hot consumers.
- Rotation and register logic stay in the top module.

## Test plan
- Reset: `rst`=0 for 1 edge, then `rst`=1, `en`=1, `dir`=0 → `out` 0001, 0010, 0100, 1000, 0001; `wrap`=1 only with the second 0001; `err`=0 throughout.
- Direction: from 0001 with `dir`=1 → 1000, 0100, 0010, 0001; switch `dir` mid-run → reverses on the next edge.
- Hold/priority: `en`=0 for 3 cycles holds 0100; `load`=1, `load_val`=1000 with `en`=1 → 1000 next edge, no rotation.
- Reset mid-run: at `out`=0100 assert `rst`=0 for one edge → 0001 next edge regardless of `en`/`load`.
- Illegal state: load 0110 → `err`=1; with `RING_COUNTER_SELFCORRECT_EN` next enabled edge → 0001, `err`=0; without → 1100, `err`=1.
- Load 0000 → `err`=1, holds 0000 under rotation when macro undefined.

Source files
------------

// File: rtl/ring_counter_pkg.sv
// Shared definitions for the one-hot ring counter and its consumers.
//   DEFAULT_WIDTH       : default ring length
//   MAX_WIDTH           : widest ring the helper function can describe
//   dir_e               : rotation direction encoding
//   default_reset_val() : one-hot reset pattern with bit 0 set
package ring_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned MAX_WIDTH     = 64;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Default reset pattern: the token starts in slot 0 (a zero width yields all-zero).
    function automatic logic [MAX_WIDTH-1:0] default_reset_val(input int unsigned width);
        logic [MAX_WIDTH-1:0] val;
        val = '0;
        if (width > 0) begin
            val[0] = 1'b1;
        end
        return val;
    endfunction

endpackage

// File: rtl/onehot_check.sv
// Combinational one-hot integrity checker.
// Flags any vector that does not have exactly one bit set.
// The all-zero vector and multi-hot vectors are both flagged.
// Ports:
//   vec_i : vector under test (WIDTH bits)
//   err_o : 1 when vec_i is not exactly one-hot (combinational)
module onehot_check #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             err_o
);

    always_comb begin
        err_o = ($countones(vec_i) != 1);
    end

endmodule

// File: rtl/ring_counter_core.sv
// One-hot ring counter used as a round-robin slot/phase sequencer.
// A single token circulates through a WIDTH-bit register, advancing one
// position per enabled clock in the direction selected by dir.
// Priority per rising edge: reset (rst low) > load > en > hold.
// Optional feature macro: RING_COUNTER_SELFCORRECT_EN
//   defined     : an enabled edge on an illegal state reloads RESET_VAL
//   not defined : illegal states rotate as-is and err stays asserted
// Ports:
//   clk      : clock, rising edge active
//   rst      : synchronous active-low reset
//   en       : advance enable
//   dir      : 0 rotate left (toward MSB), 1 rotate right
//   load     : synchronous load of load_val
//   load_val : value to load (any pattern accepted)
//   out      : registered ring state
//   wrap     : registered; 1 when a rotation lands on RESET_VAL
//   err      : combinational; 1 when out is not exactly one-hot
module ring_counter_core
    import ring_counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(default_reset_val(WIDTH))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             err
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] rot_c;
    logic             err_c;

    // Integrity check on the live state; shared with other one-hot users.
    onehot_check #(
        .WIDTH (WIDTH)
    ) u_onehot_check (
        .vec_i (out_q),
        .err_o (err_c)
    );

    // Candidate rotated value for the current direction.
    always_comb begin
        rot_c = out_q;
        if (dir_e'(dir) == DIR_RIGHT) begin
            rot_c = {out_q[0], out_q[WIDTH-1:1]};
        end else begin
            rot_c = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        end
    end

    // Next-state selection: load beats rotation; wrap only follows a rotation.
    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (load) begin
            out_d = load_val;
        end else if (en) begin
`ifdef RING_COUNTER_SELFCORRECT_EN
            if (err_c) begin
                out_d = RESET_VAL;
            end else begin
                out_d  = rot_c;
                wrap_d = (rot_c == RESET_VAL);
            end
`else
            // Rotation preserves popcount, so only a legal ring can land on RESET_VAL.
            out_d  = rot_c;
            wrap_d = (rot_c == RESET_VAL);
`endif
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q  <= RESET_VAL;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;
    assign err  = err_c;

endmodule

// File: tb/tb_ring_counter_core.sv
// Self-checking bench for ring_counter_core (WIDTH=4, default RESET_VAL).
// Directed steps from the test plan followed by randomized cycles, all
// checked against an arithmetic reference model of the ring.
module tb_ring_counter_core;

    localparam int W    = 4;
    localparam int RSTV = 1;

    logic         clk;
    logic         rst;
    logic         en;
    logic         dir;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] out;
    logic         wrap;
    logic         err;

    int checks;
    int errors;
    int exp_out;
    int exp_wrap;

    ring_counter_core #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .wrap     (wrap),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: ring positions as plain integer arithmetic.
    function automatic int rot_left(input int v);
        return (v * 2) % (1 << W) + v / (1 << (W - 1));
    endfunction

    function automatic int rot_right(input int v);
        return (v % 2) * (1 << (W - 1)) + v / 2;
    endfunction

    function automatic int ones(input int v);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) begin
            n += (v >> i) & 1;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic cyc(input logic r, input logic e, input logic d,
                       input logic l, input int lv, input string tag);
        logic bad;
        rst      = r;
        en       = e;
        dir      = d;
        load     = l;
        load_val = W'(lv);
        @(posedge clk);
        if (!r) begin
            exp_out  = RSTV;
            exp_wrap = 0;
        end else if (l) begin
            exp_out  = lv % (1 << W);
            exp_wrap = 0;
        end else if (e) begin
            bad = (ones(exp_out) != 1);
`ifdef RING_COUNTER_SELFCORRECT_EN
            if (bad) begin
                exp_out  = RSTV;
                exp_wrap = 0;
            end else begin
                exp_out  = d ? rot_right(exp_out) : rot_left(exp_out);
                exp_wrap = (exp_out == RSTV) ? 1 : 0;
            end
`else
            exp_out  = d ? rot_right(exp_out) : rot_left(exp_out);
            exp_wrap = (!bad && exp_out == RSTV) ? 1 : 0;
`endif
        end else begin
            exp_wrap = 0;
        end
        #1;
        check({tag, ".out"}, 32'(out), 32'(exp_out));
        check({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
        check({tag, ".err"}, 32'(err), 32'((ones(exp_out) != 1) ? 1 : 0));
    endtask

    initial begin
        int lv;
        checks   = 0;
        errors   = 0;
        exp_out  = RSTV;
        exp_wrap = 0;
        rst      = 1'b0;
        en       = 1'b0;
        dir      = 1'b0;
        load     = 1'b0;
        load_val = '0;

        // Reset then a full left period: 0010, 0100, 1000, 0001(wrap).
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, "reset");
        check("reset_const", 32'(out), 32'h1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, "left");
        check("left_wrap_const", 32'(wrap), 32'h1);

        // Right period: 1000, 0100, 0010, 0001(wrap).
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, "right");

        // Direction switch mid-run.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, "sw_l");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, "sw_l");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, "sw_r");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, "sw_l");
        check("at_0100", 32'(out), 32'h4);

        // Hold three cycles, then load with en (load wins).
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, "hold");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8, "load_en");
        check("load_en_const", 32'(out), 32'h8);

        // Reset mid-run overrides en and load.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, "to_0100");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8, "mid_rst");
        check("mid_rst_const", 32'(out), 32'h1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, "resume");

        // Illegal multi-hot, then all-zero under rotation.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 6, "ld_0110");
        check("err_0110", 32'(err), 32'h1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, "ill_rot");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, "ill_rot");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 0, "ld_0000");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, "zero_rot");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, "zero_rot");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) lv = 1 << $urandom_range(0, W - 1);
            else lv = $urandom_range(0, (1 << W) - 1);
            cyc(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom), ($urandom_range(0, 7) == 0), lv, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
